// File: rtl/register_bank.sv
// ---------------------------------------------------------------------------
// register_bank
//
// Purpose:
//    Eight-entry general-purpose register bank that feeds the operand
//    multiplexer. All eight registers are presented in parallel. One write
//    per cycle arrives from the bus/ALU result. R7 doubles as the program
//    counter and has its own increment control. A pending-write scoreboard
//    lets the control FSM stall on registers whose result is still
//    outstanding.
//
// Parameters:
//    WIDTH     data width of every register and data port
//    PC_RESET  value loaded into R7 (program counter) on reset
//
// Ports:
//    i_clock              system clock, all state updates on the rising edge
//    i_resetn             asynchronous active-low reset
//    i_wr_en              write strobe for register i_wr_addr
//    i_wr_addr [2:0]      destination register index
//    i_wr_data [WIDTH]    data to write
//    i_pc_incr            increment R7 by one (modulo 2^WIDTH)
//    i_rsv_en             mark register i_rsv_addr as awaiting a write
//    i_rsv_addr [2:0]     register index to reserve
//    o_r0_out..o_r7_out   current register contents (operand mux in0..in7)
//    o_pending [7:0]      scoreboard, bit n set means Rn awaits a write
//    o_pc_wrap            one-cycle pulse after R7 increments from all-ones
//
// Configuration macro:
//    REGISTER_BANK_WRITE_BYPASS_EN
//       Defined:   the addressed output shows i_wr_data in the same cycle as
//                  the write, and the written register's pending bit is shown
//                  already cleared unless it is being reserved that cycle.
//       Undefined: outputs show register state only; a write becomes visible
//                  the cycle after the clock edge.
// ---------------------------------------------------------------------------
module register_bank #(
   parameter int               WIDTH    = 16,
   parameter logic [WIDTH-1:0] PC_RESET = '0
) (
   input  logic             i_clock,
   input  logic             i_resetn,
   input  logic             i_wr_en,
   input  logic [2:0]       i_wr_addr,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_pc_incr,
   input  logic             i_rsv_en,
   input  logic [2:0]       i_rsv_addr,
   output logic [WIDTH-1:0] o_r0_out,
   output logic [WIDTH-1:0] o_r1_out,
   output logic [WIDTH-1:0] o_r2_out,
   output logic [WIDTH-1:0] o_r3_out,
   output logic [WIDTH-1:0] o_r4_out,
   output logic [WIDTH-1:0] o_r5_out,
   output logic [WIDTH-1:0] o_r6_out,
   output logic [WIDTH-1:0] o_r7_out,
   output logic [7:0]       o_pending,
   output logic             o_pc_wrap
);

   localparam logic [WIDTH-1:0] PC_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] r_regs [8];
   logic [7:0]       r_pending;
   logic             r_pc_wrap;

   logic [7:0]       w_wr_hit;
   logic [7:0]       w_rsv_hit;
   logic             w_pc_collide;
   logic             w_pc_step;
   logic             w_pc_wraps;
   logic [WIDTH-1:0] w_pc_plus1;
   logic [7:0]       w_pending_next;
   logic [WIDTH-1:0] w_view [8];
   logic [7:0]       w_pending_view;

   // Decode the write and reservation ports into one-hot masks, and work out
   // whether the PC increment survives this cycle. A write to R7 in the same
   // cycle overrides the increment, so it neither steps nor flags a wrap.
   // A reservation is applied after the write-clear so a newer producer
   // issued in the same cycle keeps the register marked pending.
   always_comb begin
      w_wr_hit       = 8'h00;
      w_rsv_hit      = 8'h00;
      if (i_wr_en) begin
         w_wr_hit = 8'(1) << i_wr_addr;
      end
      if (i_rsv_en) begin
         w_rsv_hit = 8'(1) << i_rsv_addr;
      end
      w_pc_collide   = i_wr_en && (i_wr_addr == 3'd7);
      w_pc_step      = i_pc_incr && !w_pc_collide;
      w_pc_plus1     = r_regs[7] + PC_ONE;
      w_pc_wraps     = w_pc_step && (&r_regs[7]);
      w_pending_next = (r_pending & ~w_wr_hit) | w_rsv_hit;
   end

   // Register file storage. Reset clears R0..R6 and loads the program
   // counter. The write port and the PC increment never both target R7 in
   // one cycle because w_pc_step is suppressed on a collision.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         for (int i = 0; i < 7; i++) begin
            r_regs[i] <= '0;
         end
         r_regs[7] <= PC_RESET;
      end else begin
         if (i_wr_en) begin
            r_regs[i_wr_addr] <= i_wr_data;
         end
         if (w_pc_step) begin
            r_regs[7] <= w_pc_plus1;
         end
      end
   end

   // Scoreboard and wrap flag. The wrap flag is recomputed every cycle, so
   // it is high only for the single cycle following a wrapping increment.
   always_ff @(posedge i_clock or negedge i_resetn) begin
      if (!i_resetn) begin
         r_pending <= 8'h00;
         r_pc_wrap <= 1'b0;
      end else begin
         r_pending <= w_pending_next;
         r_pc_wrap <= w_pc_wraps;
      end
   end

   // Output view. With forwarding enabled the write port is shown a cycle
   // early, including the scoreboard clear; a same-address reservation keeps
   // the bit set. The PC increment is never forwarded.
   always_comb begin
      for (int i = 0; i < 8; i++) begin
         w_view[i] = r_regs[i];
      end
      w_pending_view = r_pending;
`ifdef REGISTER_BANK_WRITE_BYPASS_EN
      if (i_wr_en) begin
         w_view[i_wr_addr] = i_wr_data;
      end
      w_pending_view = r_pending & ~(w_wr_hit & ~w_rsv_hit);
`endif
   end

   assign o_r0_out  = w_view[0];
   assign o_r1_out  = w_view[1];
   assign o_r2_out  = w_view[2];
   assign o_r3_out  = w_view[3];
   assign o_r4_out  = w_view[4];
   assign o_r5_out  = w_view[5];
   assign o_r6_out  = w_view[6];
   assign o_r7_out  = w_view[7];
   assign o_pending = w_pending_view;
   assign o_pc_wrap = r_pc_wrap;

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Eight-entry general-purpose register bank of the processor datapath, directly upstream of the operand multiplexer.
- Presents all eight registers in parallel (r0_out..r7_out) so the multiplexer's 3-bit select picks the operand.
- Accepts one write per cycle from the bus/ALU result.
- R7 doubles as program counter, with a dedicated increment control.
- Keeps a pending-write scoreboard so the control FSM can stall on registers with an outstanding result.

Parameters:
- WIDTH, 16, data width of every register and port.
- PC_RESET, 0, reset value of R7 (program counter).

Ports:
- Clock  input  1  system clock; all state updates on rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- wr_en  input  1  write strobe for the addressed register.
- wr_addr  input  3  destination register index 0..7.
- wr_data  input  WIDTH  data to write.
- pc_incr  input  1  increment R7 by 1.
- rsv_en  input  1  mark a register as having a pending write.
- rsv_addr  input  3  register index to reserve.
- r0_out..r7_out  output  WIDTH each  current register contents; feed the operand multiplexer inputs in0..in7.
- pending  output  8  scoreboard; bit n = 1 means Rn awaits a write.
- pc_wrap  output  1  one-cycle pulse when an R7 increment wraps from all-ones to 0.

Behaviour:
Reset:
- Resetn low immediately forces R0..R6 = 0, R7 = PC_RESET, pending = 8'h00, pc_wrap = 0, independent of Clock.
- Release is synchronous in effect: first update on the first rising edge with Resetn high.
- Reset asserted mid-operation discards any in-flight write, increment or reservation.

Writes:
- With wr_en = 1 at a rising edge, R[wr_addr] <= wr_data.
- Output visible the cycle after the edge (1-cycle latency) unless WRITE_BYPASS_EN is defined.

PC increment:
- With pc_incr = 1, R7 <= R7 + 1, truncated to WIDTH (modulo 2^WIDTH).
- pc_wrap = 1 for exactly the cycle after an increment from {WIDTH{1}} to 0; otherwise 0.
- wr_en with wr_addr = 7 and pc_incr in the same cycle: the write wins, the increment is dropped, and pc_wrap stays 0.

Scoreboard:
- rsv_en sets pending[rsv_addr]; wr_en clears pending[wr_addr].
- Same register reserved and written in the same cycle: the reservation wins, so pending stays 1 (a newer producer has been issued). The data is still written.
- Reserve and write to different registers in the same cycle: both take effect.
- Reserving an already-pending register keeps it 1; no error.
- Writing a non-pending register is a legal plain write; pending stays 0.
- pc_incr does not affect pending[7].

General:
- No read latency: r*_out are direct register outputs.
- No state machine beyond the registers, scoreboard and pc_wrap flop.

Optional Feature:
- Macro: REGISTER_BANK_WRITE_BYPASS_EN.
- Defined: r[wr_addr]_out combinationally shows wr_data while wr_en = 1, in the same cycle as the write.
  - Forwarding applies to the write port only, not to pc_incr.
  - Register state still updates at the edge.
  - pending[wr_addr] is also shown as already cleared, unless rsv_en hits the same address.
- Not defined: outputs reflect register state only; written data appears one cycle after the edge.

Test Plan:
- Reset: assert Resetn = 0 mid-cycle with registers holding nonzero data -> all r0..r6_out = 16'h0000, r7_out = PC_RESET, pending = 8'h00 without waiting for a clock edge.
- Write/readback: write 16'h1234 to R3 -> r3_out = 16'h1234 one cycle later (same cycle with bypass); all other outputs unchanged.
- PC wrap: preload R7 = 16'hFFFF, pulse pc_incr -> r7_out = 16'h0000 and pc_wrap = 1 for exactly one cycle; a further increment gives 16'h0001 with pc_wrap = 0.
- PC collision: wr_en to R7 with 16'h0040 plus pc_incr in the same cycle -> r7_out = 16'h0040, pc_wrap = 0.
- Scoreboard:
  - Reserve R5 -> pending = 8'h20.
  - Write R5 -> pending = 8'h00.
  - Reserve and write R2 in the same cycle -> pending[2] = 1 and r2_out holds the written value.
- Concurrent ops: reserve R1 while writing R6 with 16'hBEEF -> pending[1] = 1, pending[6] = 0, r6_out = 16'hBEEF.
